store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write buffer between the MEM-stage pipeline and the data memory (Data_Mem port: MemSum, WriteData, MemWrite, MemRead, Funct3).
- Stores are accepted in one cycle and drained to memory in FIFO order, one per cycle.
- Loads are arbitrated onto the same single memory port.
- A load is held off while any buffered store targets the same word, so it never reads stale data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, 2..16.
- CNT_W, 3, width of count output; equals log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- st_valid  in  1  store request from pipeline.
- st_ready  out  1  buffer can accept a store this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  store data; the byte/half is in the low bits.
- st_funct3  in  3  store width code (000 sb, 001 sh, 010 sw); passed through unchecked.
- ld_valid  in  1  load request from pipeline.
- ld_addr  in  32  load byte address.
- ld_funct3  in  3  load width code; passed through.
- ld_stall  out  1  load not issued this cycle; pipeline holds the request.
- ld_rsp_valid  out  1  registered; high the cycle after a load is issued, when Data_Mem ReadData is valid.
- mem_sum  out  32  memory address (to MemSum).
- mem_wdata  out  32  memory write data (to WriteData).
- mem_write  out  1  to MemWrite.
- mem_read  out  1  to MemRead.
- mem_funct3  out  3  to Funct3.
- count  out  CNT_W  number of occupied entries.
- empty  out  1  count == 0.

Behaviour:
- Storage: circular FIFO of DEPTH entries {addr, data, funct3}. Head/tail pointers wrap modulo DEPTH; count tracks occupancy.
- Push: occurs when st_valid && st_ready. st_ready = (count < DEPTH).
  - A store is never accepted when full, even if a pop happens in the same cycle.
- Hazard: asserted when ld_valid and any occupied entry has addr[31:2] == ld_addr[31:2].
  - The entry being drained this cycle still counts.
  - A store pushed in the same cycle does not count; the pipeline orders it after the load.
- Port arbitration, evaluated each cycle, combinational, first match wins:
  1. ld_valid && !hazard && count < DEPTH: issue the load.
     - mem_read=1, mem_write=0, mem_sum=ld_addr, mem_funct3=ld_funct3, mem_wdata=0, ld_stall=0.
  2. count > 0: drain the head entry.
     - mem_write=1, mem_read=0, mem_sum/mem_wdata/mem_funct3 = head fields.
     - Pop at the clock edge. ld_stall = ld_valid.
  3. Otherwise idle: all mem_* = 0, ld_stall = ld_valid.
- When full, drain takes priority over a non-hazard load. Loads stall until count < DEPTH. This bounds store starvation.
- A hazard load stalls while the drain proceeds. It is issued on the first cycle after the last matching entry has popped.
- Simultaneous push and pop leave count unchanged. Push into an empty buffer is not drained in the same cycle; the earliest write is the next cycle.
- ld_rsp_valid <= issued-load of the previous cycle. Load-to-data latency is 1 cycle, matching Data_Mem's registered ReadData.
- Reset (reset==0, asynchronous):
  - Pointers, count and ld_rsp_valid are cleared to 0.
  - All buffered stores are discarded.
  - While reset is asserted, st_ready=0, ld_stall=ld_valid, and mem_write, mem_read, mem_sum, mem_wdata, mem_funct3 = 0.
  - Reset mid-drain aborts with no further writes. After release: empty=1, st_ready=1.

Decomposition:
- Shared package (alongside the existing memory-stage constants) holds:
  - F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - DEPTH default.
  - Entry record type {addr[31:0], data[31:0], funct3[2:0]}.
- One sub-module is natural: sb_addr_match. It takes all entry word addresses, the valid mask and ld_addr, and outputs hazard; it is a parallel compare plus OR reduce.
- FIFO storage, arbitration and counters stay in store_buffer.

Test Plan:
- Reset release, then st_valid with addr=0x10, data=0xA5, funct3=000 → st_ready=1, count=1. Next cycle: mem_write=1, mem_sum=0x10, mem_wdata=0xA5. Following cycle: empty=1.
- Push 4 stores (0x00, 0x04, 0x08, 0x0C) back-to-back with no drain gap → st_ready=0 when count=4, and a 5th store is held. Drain order is 0x00, 0x04, 0x08, 0x0C.
- Buffer holds store to 0x21. Load ld_addr=0x23, funct3=000 → ld_stall=1 until the 0x21 write cycle completes. Then mem_read=1, mem_sum=0x23. ld_rsp_valid=1 one cycle later with Data_Mem returning the stored byte.
- Buffer holds stores to 0x40 and 0x44. Load to 0x80 → load issued immediately (mem_read=1, mem_write=0), drain paused that cycle, count stays 2.
- Full buffer (count=4) with a non-hazard load pending → mem_write=1 and ld_stall=1 for one cycle. Load issued the next cycle at count=3.
- Assert reset low mid-drain with count=3 → mem_write drops to 0 immediately (asynchronous). After release: count=0, empty=1, and no write to the remaining addresses ever appears.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: memory-stage width codes, buffer depth and entry record
package store_buffer_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int SB_DEPTH = 4;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  funct3;
  } sb_entry_t;
endpackage

// File: rtl/sb_addr_match.sv
// sb_addr_match: word-address compare of a load against every occupied entry
module sb_addr_match #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*30-1:0] i_words,
  input  logic [DEPTH-1:0]    i_valid,
  input  logic [29:0]         i_ld_word,
  output logic                o_hit
);
  logic [DEPTH-1:0] w_eq;
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign w_eq[g] = i_valid[g] && (i_words[g*30 +: 30] == i_ld_word);
  end
  assign o_hit = |w_eq;
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO sharing one data-memory port with loads
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [2:0]       st_funct3,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  input  logic [2:0]       ld_funct3,
  output logic             ld_stall,
  output logic             ld_rsp_valid,
  output logic [31:0]      mem_sum,
  output logic [31:0]      mem_wdata,
  output logic             mem_write,
  output logic             mem_read,
  output logic [2:0]       mem_funct3,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  sb_entry_t          r_mem [DEPTH];
  logic [PTR_W-1:0]   r_head, r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_ld_rsp;
  logic [DEPTH-1:0]   w_valid;
  logic [DEPTH*30-1:0] w_words;
  logic               w_hit, w_not_full, w_issue, w_drain, w_push;
  sb_entry_t          w_head;
  // occupancy mask: entry i is live when its distance from head is below count
  always_comb begin
    logic [PTR_W-1:0] off;
    off = '0;
    w_valid = '0;
    w_words = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - r_head;
      w_valid[i] = {1'b0, off} < r_count;
      w_words[i*30 +: 30] = r_mem[i].addr[31:2];
    end
  end
  sb_addr_match #(.DEPTH(DEPTH)) u_match (
    .i_words  (w_words),
    .i_valid  (w_valid),
    .i_ld_word(ld_addr[31:2]),
    .o_hit    (w_hit)
  );
  assign w_head     = r_mem[r_head];
  assign w_not_full = r_count < CNT_W'(DEPTH);
  assign st_ready   = reset && w_not_full;
  assign w_push     = st_valid && st_ready;
  assign w_issue    = reset && ld_valid && !w_hit && w_not_full;
  assign w_drain    = reset && !w_issue && (r_count != '0);
  always_comb begin
    mem_read   = w_issue;
    mem_write  = w_drain;
    mem_sum    = w_issue ? ld_addr : w_drain ? w_head.addr : '0;
    mem_wdata  = w_drain ? w_head.data : '0;
    mem_funct3 = w_issue ? ld_funct3 : w_drain ? w_head.funct3 : '0;
    ld_stall   = ld_valid && !w_issue;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_ld_rsp <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_drain) r_head <= r_head + 1'b1;
      r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_drain);
      r_ld_rsp <= w_issue;
    end
  end
  assign count        = r_count;
  assign empty        = r_count == '0;
  assign ld_rsp_valid = r_ld_rsp;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed checks of store_buffer against a small data-memory model
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0, ld_valid = 1'b0;
  logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic [2:0]  st_funct3 = '0, ld_funct3 = '0;
  logic        st_ready, ld_stall, ld_rsp_valid, mem_write, mem_read, empty;
  logic [31:0] mem_sum, mem_wdata;
  logic [2:0]  mem_funct3;
  logic [2:0]  count;
  int          n_checks = 0, n_fail = 0, n_wr = 0;
  logic        watch = 1'b0;
  logic [31:0] dmem [64];
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_stall(ld_stall), .ld_rsp_valid(ld_rsp_valid),
    .mem_sum(mem_sum), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read), .mem_funct3(mem_funct3),
    .count(count), .empty(empty)
  );

  initial for (int i = 0; i < 64; i++) dmem[i] = '0;

  // Data_Mem stand-in: byte/half/word writes, registered word read
  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_funct3)
        3'b000: dmem[mem_sum[7:2]][mem_sum[1:0]*8 +: 8] <= mem_wdata[7:0];
        3'b001: dmem[mem_sum[7:2]][mem_sum[1]*16 +: 16] <= mem_wdata[15:0];
        default: dmem[mem_sum[7:2]] <= mem_wdata;
      endcase
    end
    if (mem_read) rdata <= dmem[mem_sum[7:2]];
    if (watch && mem_write) n_wr <= n_wr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f;
  endtask

  initial begin
    ld_valid = 1'b1; ld_addr = 32'h80;
    #3;
    chk("rst_st_ready", st_ready, 0);
    chk("rst_ld_stall", ld_stall, 1);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    ld_valid = 1'b0;
    step(); reset = 1'b1; #1;
    chk("rel_empty", empty, 1);
    chk("rel_st_ready", st_ready, 1);
    // single store then drain
    step(); store(32'h10, 32'hA5, 3'b000); #1;
    chk("t1_ready", st_ready, 1);
    chk("t1_no_same_cycle_drain", mem_write, 0);
    step(); st_valid = 1'b0; #1;
    chk("t1_count", count, 1);
    chk("t1_write", mem_write, 1);
    chk("t1_sum", mem_sum, 32'h10);
    chk("t1_wdata", mem_wdata, 32'hA5);
    step(); #1;
    chk("t1_empty", empty, 1);
    chk("t1_idle_write", mem_write, 0);
    // fill to DEPTH while loads hold the port, then check full behaviour and drain order
    ld_valid = 1'b1; ld_addr = 32'h80; ld_funct3 = 3'b010;
    step(); store(32'h00, 32'h1, 3'b010); #1;
    chk("t2_load_issue", mem_read, 1);
    step(); store(32'h04, 32'h2, 3'b010); #1;
    chk("t2_count1", count, 1);
    step(); store(32'h08, 32'h3, 3'b010); #1;
    chk("t2_count2", count, 2);
    step(); store(32'h0C, 32'h4, 3'b010); #1;
    chk("t2_count3", count, 3);
    chk("t2_ready3", st_ready, 1);
    step(); store(32'h10, 32'h5, 3'b010); #1;
    chk("t2_full_count", count, 4);
    chk("t2_full_ready", st_ready, 0);
    chk("t2_full_write", mem_write, 1);
    chk("t2_full_sum", mem_sum, 32'h00);
    chk("t2_full_stall", ld_stall, 1);
    step(); st_valid = 1'b0; #1;
    chk("t2_after_count", count, 3);
    chk("t2_after_read", mem_read, 1);
    chk("t2_after_stall", ld_stall, 0);
    chk("t2_after_write", mem_write, 0);
    step(); ld_valid = 1'b0; #1;
    chk("t2_rsp", ld_rsp_valid, 1);
    chk("t2_drain1", mem_sum, 32'h04);
    chk("t2_drain1_data", mem_wdata, 32'h2);
    step(); #1;
    chk("t2_rsp_low", ld_rsp_valid, 0);
    chk("t2_drain2", mem_sum, 32'h08);
    step(); #1;
    chk("t2_drain3", mem_sum, 32'h0C);
    chk("t2_count_last", count, 1);
    step(); #1;
    chk("t2_empty", empty, 1);
    // same-word hazard: load waits for the byte store to reach memory
    step(); store(32'h21, 32'h5A, 3'b000); #1;
    step(); st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h23; ld_funct3 = 3'b000; #1;
    chk("t3_stall", ld_stall, 1);
    chk("t3_write", mem_write, 1);
    chk("t3_wsum", mem_sum, 32'h21);
    step(); #1;
    chk("t3_issue", mem_read, 1);
    chk("t3_rsum", mem_sum, 32'h23);
    chk("t3_no_stall", ld_stall, 0);
    step(); ld_valid = 1'b0; #1;
    chk("t3_rsp", ld_rsp_valid, 1);
    chk("t3_rdata", rdata[15:8], 32'h5A);
    // non-hazard load pre-empts the drain
    step(); ld_valid = 1'b1; ld_addr = 32'h200; store(32'h40, 32'h11, 3'b010); #1;
    step(); store(32'h44, 32'h22, 3'b010); #1;
    step(); st_valid = 1'b0; ld_addr = 32'h80; #1;
    chk("t4_read", mem_read, 1);
    chk("t4_no_write", mem_write, 0);
    chk("t4_sum", mem_sum, 32'h80);
    chk("t4_count", count, 2);
    step(); ld_valid = 1'b0; #1;
    chk("t4_count_held", count, 2);
    chk("t4_drain", mem_sum, 32'h40);
    step(); #1;
    chk("t4_drain2", mem_sum, 32'h44);
    step(); #1;
    chk("t4_empty", empty, 1);
    // asynchronous reset in the middle of a drain
    step(); ld_valid = 1'b1; ld_addr = 32'h300; store(32'h50, 32'h7, 3'b010); #1;
    step(); store(32'h54, 32'h8, 3'b010); #1;
    step(); store(32'h58, 32'h9, 3'b010); #1;
    step(); st_valid = 1'b0; ld_valid = 1'b0; #1;
    chk("t6_count", count, 3);
    chk("t6_write", mem_write, 1);
    reset = 1'b0; #1;
    chk("t6_rst_write", mem_write, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_ready", st_ready, 0);
    step(); reset = 1'b1; watch = 1'b1;
    repeat (6) step();
    chk("t6_no_writes", n_wr, 0);
    chk("t6_empty", empty, 1);
    chk("t6_ready", st_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
